// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register bank: FSM state encoding and
// frame geometry helpers.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2,
    ERR  = 2'd3
  } spi_state_e;

  // Total frame length: RW bit, address field, data field.
  function automatic int frame_w(input int aw, input int dw);
    return 1 + aw + dw;
  endfunction

  // Bit counter width, able to hold 0..FRAME_W.
  function automatic int cnt_w(input int aw, input int dw);
    return $clog2(frame_w(aw, dw) + 1);
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer followed by one history flop; edges are derived
// from the s2/s3 pair so every consumer sees the same clean event.
module sync_edge_det #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q, s2_q, s3_q;

  // Synchronizer chain plus edge-history flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
      s3_q <= RST_VAL;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign lvl_o  = s2_q;
  assign rise_o = s2_q & ~s3_q;
  assign fall_o = ~s2_q & s3_q;

endmodule

// File: rtl/spi_reg_bank.sv
// SPI mode-0 slave register bank. Frames are RW, address, data (MSB first),
// all sampled in the clk domain through synchronizers. Writes commit when
// nCS rises after an exact-length frame; reads shift the addressed register
// out on CIPO during the data phase.
module spi_reg_bank
  import spi_pkg::*;
#(
  parameter int NUM_REGS = 5,
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8,
  parameter logic [NUM_REGS*DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         nCS,
  input  logic                         SCLK,
  input  logic                         COPI,
  output logic                         CIPO,
  output logic                         cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0]   regs_o,
  output logic                         wr_stb,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic [7:0]                   err_cnt
);

  localparam int FRAME_W = frame_w(ADDR_W, DATA_W);
  localparam int CNT_W   = cnt_w(ADDR_W, DATA_W);

  logic ncs_lvl, ncs_rise, ncs_fall;
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic copi_lvl, copi_rise, copi_fall;
  logic unused_edges;

  sync_edge_det #(.RST_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst(rst), .d_i(nCS),
    .lvl_o(ncs_lvl), .rise_o(ncs_rise), .fall_o(ncs_fall)
  );
  sync_edge_det #(.RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .d_i(SCLK),
    .lvl_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );
  sync_edge_det #(.RST_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst(rst), .d_i(COPI),
    .lvl_o(copi_lvl), .rise_o(copi_rise), .fall_o(copi_fall)
  );

  assign unused_edges = ^{sclk_lvl, copi_rise, copi_fall};

  spi_state_e                 state_q;
  logic [CNT_W-1:0]           cnt_q;
  logic [FRAME_W-1:0]         sh_q;      // frame bit k lands at FRAME_W-1-k
  logic [FRAME_W-1:0]         sh_ins;
  logic [DATA_W-1:0]          tx_q;
  logic                       oe_q;
  logic                       ld_pend_q;
  logic                       armed_q;
  logic [1:0]                 settle_q;
  logic [NUM_REGS*DATA_W-1:0] regs_q;
  logic                       wr_stb_q;
  logic [ADDR_W-1:0]          wr_addr_q;
  logic [7:0]                 err_q;

  logic                       fr_rw;
  logic [ADDR_W-1:0]          fr_addr;
  logic [DATA_W-1:0]          fr_data;
  logic                       full;
  logic                       addr_ok;
  logic                       sample;
  logic                       do_commit;
  logic                       bad_frame;
  logic [DATA_W-1:0]          rd_word;

  assign fr_rw     = sh_q[FRAME_W-1];
  assign fr_addr   = sh_q[DATA_W +: ADDR_W];
  assign fr_data   = sh_q[DATA_W-1:0];
  assign full      = (int'(cnt_q) == FRAME_W);
  assign addr_ok   = (int'(fr_addr) < NUM_REGS);
  assign sample    = sclk_rise & ~ncs_lvl;
  assign do_commit = ncs_rise && (state_q == DATA) && full && fr_rw && addr_ok;
  assign bad_frame = ncs_rise && ((state_q == HDR) || (state_q == ERR) ||
                                  ((state_q == DATA) && !full));

  // Place the synchronized COPI bit at the slot selected by the bit counter.
  always_comb begin
    sh_ins = sh_q;
    for (int i = 0; i < FRAME_W; i++)
      if (int'(cnt_q) == i) sh_ins[FRAME_W-1-i] = copi_lvl;
  end

  // Read mux; unimplemented addresses read as zero.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (int'(fr_addr) == i) rd_word = regs_q[i*DATA_W +: DATA_W];
  end

  // Frame FSM: header/data capture, read shifter, and post-reset arming so a
  // frame already in flight at reset release is never picked up mid-way.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sh_q      <= '0;
      tx_q      <= '0;
      oe_q      <= 1'b0;
      ld_pend_q <= 1'b0;
      armed_q   <= 1'b0;
      settle_q  <= 2'd0;
    end else begin
      if (settle_q != 2'd3) settle_q <= settle_q + 2'd1;
      if (settle_q == 2'd3 && ncs_lvl) armed_q <= 1'b1;
      ld_pend_q <= 1'b0;
      if (ncs_rise) begin
        state_q <= IDLE;
        tx_q    <= '0;
        oe_q    <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (ncs_fall && armed_q) begin
              state_q <= HDR;
              cnt_q   <= '0;
              sh_q    <= '0;
            end
          end
          HDR: begin
            if (sample) begin
              sh_q  <= sh_ins;
              cnt_q <= cnt_q + CNT_W'(1);
              if (int'(cnt_q) == ADDR_W) begin
                state_q   <= DATA;
                ld_pend_q <= 1'b1;
              end
            end
          end
          DATA: begin
            if (ld_pend_q && !fr_rw) begin
              tx_q <= rd_word;
              oe_q <= 1'b1;
            end else if (sclk_fall && oe_q && int'(cnt_q) > ADDR_W + 1) begin
              // The falling edge after the header's last bit is skipped so
              // the master samples the MSB on the first data rise.
              if (full) begin
                tx_q <= '0;
                oe_q <= 1'b0;
              end else begin
                tx_q <= tx_q << 1;
              end
            end
            if (sample) begin
              if (full) begin
                state_q <= ERR;
                tx_q    <= '0;
                oe_q    <= 1'b0;
              end else begin
                sh_q  <= sh_ins;
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end
          end
          default: ;  // ERR: absorb bits until nCS rises
        endcase
      end
    end
  end

  // Register file, commit strobe and saturating error counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q    <= RESET_VAL;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      err_q     <= '0;
    end else begin
      wr_stb_q <= do_commit;
      if (do_commit) begin
        wr_addr_q <= fr_addr;
        for (int i = 0; i < NUM_REGS; i++)
          if (int'(fr_addr) == i) regs_q[i*DATA_W +: DATA_W] <= fr_data;
      end
      if (bad_frame && err_q != 8'hFF) err_q <= err_q + 8'd1;
    end
  end

  assign CIPO    = tx_q[DATA_W-1];
  assign cipo_oe = oe_q;
  assign regs_o  = regs_q;
  assign wr_stb  = wr_stb_q;
  assign wr_addr = wr_addr_q;
  assign err_cnt = err_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench: default bank (A) and a 16x16-bit bank (B) driven by
// bit-banged SPI frames with hand-computed expectations.
module tb_spi_reg_bank;

  localparam logic [255:0] RV_B = 256'hA5A5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ncs_a = 1'b1, sclk_a = 1'b0, copi_a = 1'b0;
  logic ncs_b = 1'b1, sclk_b = 1'b0, copi_b = 1'b0;
  logic cipo_a, oe_a, stb_a, cipo_b, oe_b, stb_b;
  logic [39:0]  regs_a;
  logic [6:0]   wa_a;
  logic [7:0]   err_a;
  logic [255:0] regs_b;
  logic [3:0]   wa_b;
  logic [7:0]   err_b;
  int n_chk = 0, n_fail = 0;
  int stb_n_a = 0, stb_n_b = 0;

  always #5 clk = ~clk;

  spi_reg_bank u_a (
    .clk(clk), .rst(rst), .nCS(ncs_a), .SCLK(sclk_a), .COPI(copi_a),
    .CIPO(cipo_a), .cipo_oe(oe_a), .regs_o(regs_a), .wr_stb(stb_a),
    .wr_addr(wa_a), .err_cnt(err_a)
  );

  spi_reg_bank #(.NUM_REGS(16), .ADDR_W(4), .DATA_W(16), .RESET_VAL(RV_B)) u_b (
    .clk(clk), .rst(rst), .nCS(ncs_b), .SCLK(sclk_b), .COPI(copi_b),
    .CIPO(cipo_b), .cipo_oe(oe_b), .regs_o(regs_b), .wr_stb(stb_b),
    .wr_addr(wa_b), .err_cnt(err_b)
  );

  always @(negedge clk) begin
    if (stb_a) stb_n_a <= stb_n_a + 1;
    if (stb_b) stb_n_b <= stb_n_b + 1;
  end

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic pins(input int d, input logic n, input logic s, input logic c);
    if (d == 0) begin ncs_a = n; sclk_a = s; copi_a = c; end
    else        begin ncs_b = n; sclk_b = s; copi_b = c; end
  endtask

  // One frame, MSB first from fr[nbits-1]. CIPO/oe are captured just before
  // each SCLK rise; tr records wr_stb on the 6 negedges after nCS rises.
  task automatic xfer(input int d, input int nbits, input logic [31:0] fr, input int rst_at,
                      output logic [31:0] cc, output logic [31:0] co, output logic [5:0] tr);
    cc = '0; co = '0; tr = '0;
    pins(d, 1'b0, 1'b0, 1'b0);
    repeat (8) @(negedge clk);
    for (int k = 0; k < nbits; k++) begin
      if (k == rst_at) begin
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
      end
      pins(d, 1'b0, 1'b0, fr[nbits-1-k]);
      repeat (4) @(negedge clk);
      cc = {cc[30:0], (d == 0) ? cipo_a : cipo_b};
      co = {co[30:0], (d == 0) ? oe_a : oe_b};
      pins(d, 1'b0, 1'b1, fr[nbits-1-k]);
      repeat (8) @(negedge clk);
      pins(d, 1'b0, 1'b0, fr[nbits-1-k]);
      repeat (4) @(negedge clk);
    end
    repeat (8) @(negedge clk);
    pins(d, 1'b1, 1'b0, 1'b0);
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      tr[j] = (d == 0) ? stb_a : stb_b;
    end
    repeat (10) @(negedge clk);
  endtask

  initial begin
    logic [31:0] cc, co;
    logic [5:0]  tr;
    int s0;

    repeat (5) @(negedge clk);
    chk("rst_regs_a", regs_a, 40'h0);
    chk("rst_regs_b", regs_b, RV_B);
    chk("rst_stb",    {stb_a, stb_b}, 2'b00);
    chk("rst_waddr",  {wa_a, wa_b}, 11'h0);
    chk("rst_err",    {err_a, err_b}, 16'h0);
    chk("rst_cipo",   {cipo_a, oe_a, cipo_b, oe_b}, 4'b0000);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // write 0x82 -> addr 3
    s0 = stb_n_a;
    xfer(0, 16, 32'h8382, -1, cc, co, tr);
    chk("w3_stb_timing", tr, 6'b000100);
    chk("w3_reg3",  regs_a[31:24], 8'h82);
    chk("w3_regs",  regs_a, 40'h0082000000);
    chk("w3_nstb",  stb_n_a - s0, 1);
    chk("w3_waddr", wa_a, 7'h03);
    chk("w3_err",   err_a, 8'h00);

    // write 0x5A -> addr 2, read it back
    xfer(0, 16, 32'h825A, -1, cc, co, tr);
    chk("w2_regs", regs_a, 40'h00825A0000);
    xfer(0, 16, 32'h0200, -1, cc, co, tr);
    chk("r2_cipo", cc[7:0], 8'h5A);
    chk("r2_oe",   co[15:0], 16'h00FF);
    chk("r2_nostb", tr, 6'b000000);
    chk("r2_regs", regs_a, 40'h00825A0000);
    chk("r2_oe_after", {oe_a, cipo_a}, 2'b00);
    chk("r2_err",  err_a, 8'h00);

    // short and long write frames
    xfer(0, 15, 32'h40FF, -1, cc, co, tr);
    chk("w15_nostb", tr, 6'b000000);
    xfer(0, 17, 32'h103FF, -1, cc, co, tr);
    chk("w17_nostb", tr, 6'b000000);
    chk("wbad_err",  err_a, 8'h02);
    chk("wbad_regs", regs_a, 40'h00825A0000);

    // out-of-range address: silently ignored, reads zero
    xfer(0, 16, 32'h90FF, -1, cc, co, tr);
    chk("w10_nostb", tr, 6'b000000);
    chk("w10_err",   err_a, 8'h02);
    chk("w10_regs",  regs_a, 40'h00825A0000);
    xfer(0, 16, 32'h1000, -1, cc, co, tr);
    chk("r10_cipo",  cc[7:0], 8'h00);
    chk("r10_err",   err_a, 8'h02);

    // short read counts as an error
    xfer(0, 9, 32'h004, -1, cc, co, tr);
    chk("r9_err",  err_a, 8'h03);
    chk("r9_regs", regs_a, 40'h00825A0000);

    // SCLK activity with nCS high
    for (int k = 0; k < 4; k++) begin
      pins(0, 1'b1, 1'b1, 1'b1); repeat (8) @(negedge clk);
      pins(0, 1'b1, 1'b0, 1'b0); repeat (8) @(negedge clk);
    end
    chk("idle_sclk_err",  err_a, 8'h03);
    chk("idle_sclk_regs", regs_a, 40'h00825A0000);

    // reset after 9 bits of a write, then a clean write
    xfer(0, 16, 32'h83AA, 9, cc, co, tr);
    chk("mrst_nostb", tr, 6'b000000);
    chk("mrst_regs",  regs_a, 40'h0);
    chk("mrst_err",   err_a, 8'h00);
    xfer(0, 16, 32'h8111, -1, cc, co, tr);
    chk("post_stb",   tr, 6'b000100);
    chk("post_regs",  regs_a, 40'h0000001100);
    chk("post_waddr", wa_a, 7'h01);

    // wide bank: write 0xBEEF -> addr 0xF and read it back
    s0 = stb_n_b;
    xfer(1, 21, 32'h1FBEEF, -1, cc, co, tr);
    chk("b_stb_timing", tr, 6'b000100);
    chk("b_reg15", regs_b[255:240], 16'hBEEF);
    chk("b_regs",  regs_b, {16'hBEEF, 240'h0} | RV_B);
    chk("b_nstb",  stb_n_b - s0, 1);
    chk("b_waddr", wa_b, 4'hF);
    chk("b_err",   err_b, 8'h00);
    xfer(1, 21, 32'h0F0000, -1, cc, co, tr);
    chk("b_rd_cipo", cc[15:0], 16'hBEEF);
    chk("b_rd_oe",   co[20:0], 21'h00FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_reg_bank.md
SPI_REG_BANK -- requirements
Module: spi_reg_bank

Interface
REQ-001 SHALL have parameter NUM_REGS, default 5, number of implemented registers (1..2**ADDR_W).
REQ-002 SHALL have parameter ADDR_W, default 7, address field width.
REQ-003 SHALL have parameter DATA_W, default 8, data field width; FRAME_W = 1+ADDR_W+DATA_W.
REQ-004 SHALL have parameter RESET_VAL, default all-zero, NUM_REGS*DATA_W register reset image.
REQ-005 clk  in  1  sole clock; SCLK/nCS/COPI are sampled on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 nCS  in  1  chip select, active low, asynchronous to clk.
REQ-008 SCLK  in  1  SPI clock, mode 0, at most clk/8.
REQ-009 COPI  in  1  serial data in, MSB first.
REQ-010 CIPO  out  1  serial read data, MSB first.
REQ-011 cipo_oe  out  1  high while a read data phase is in progress.
REQ-012 regs_o  out  NUM_REGS*DATA_W  register contents, reg i at [i*DATA_W +: DATA_W].
REQ-013 wr_stb  out  1  one-cycle pulse when a register is committed.
REQ-014 wr_addr  out  ADDR_W  address of the last commit.
REQ-015 err_cnt  out  8  saturating count of rejected frames.

Function
REQ-016 SHALL pass nCS, SCLK, and COPI through a two-flop synchronizer, then a third flop for edge detection; edges are s2/s3 comparisons only.
REQ-017 Frame layout: bit 0 is RW (1=write, 0=read), then ADDR_W address bits, then DATA_W data bits; every bit is sampled on a synchronized SCLK rising edge while nCS is low.
REQ-018 FSM states SHALL be IDLE, HDR, DATA, ERR.
REQ-019 IDLE->HDR on synchronized nCS falling edge; bit counter and shift register cleared.
REQ-020 HDR->DATA when counter reaches 1+ADDR_W; address and RW latched.
REQ-021 DATA->ERR on a sampled bit beyond FRAME_W; the counter saturates.
REQ-022 On a synchronized nCS rising edge from any state, the FSM SHALL return to IDLE.
REQ-023 A write frame SHALL commit only if nCS rises with exactly FRAME_W bits received, RW=1, and address < NUM_REGS.
REQ-024 A commit SHALL update regs_o, pulse wr_stb, and load wr_addr on the 3rd clk edge after the nCS pin rise, counting the edge that first samples it as the 1st.
REQ-025 A write frame that ends with the wrong bit count, or passes through ERR, SHALL NOT commit and SHALL increment err_cnt by 1, saturating at 255.
REQ-026 A write to address >= NUM_REGS SHALL be ignored without commit and without an error.
REQ-027 Read: on entry to DATA with RW=0, the tx shifter SHALL load reg[addr], or 0 if addr >= NUM_REGS, and cipo_oe SHALL go high.
REQ-028 Read: CIPO SHALL present the MSB immediately and advance one bit on each synchronized SCLK falling edge.
REQ-029 Read frames SHALL never modify registers; a wrong bit count on a read SHALL count as an error.
REQ-030 Outside an active read data phase, CIPO SHALL be 0 and cipo_oe 0.
REQ-031 SCLK edges while nCS is high SHALL be ignored.
REQ-032 An nCS falling edge in the same cycle as a pending commit SHALL let the commit complete and start the new frame cleanly.

Reset
REQ-033 While rst is high, regs_o SHALL equal RESET_VAL; wr_stb, wr_addr, err_cnt, CIPO, and cipo_oe SHALL be 0; the FSM SHALL be in IDLE.
REQ-034 Synchronizer flops SHALL reset to nCS=1, SCLK=0, COPI=0.
REQ-035 A reset mid-frame SHALL discard the frame; if nCS is still low at reset release, the block SHALL wait for nCS high and a new falling edge.

Structure
REQ-036 Shared package spi_pkg SHALL hold the FSM state enum and the FRAME_W and counter-width (clog2(FRAME_W+1)) functions.
REQ-037 The synchronizer plus edge detector SHALL be one sub-module, sync_edge_det, instantiated once per input.

Verification
REQ-038 Defaults, write 0x82 to addr 0x03 (frame 1_0000011_10000010) -> regs_o[31:24]=0x82, exactly one wr_stb, wr_addr=0x03, err_cnt=0.
REQ-039 Write 0x5A to addr 0x02, then a read frame of addr 0x02 -> CIPO shifts 01011010 during the data phase, cipo_oe high for exactly 8 bits, regs unchanged.
REQ-040 A 15-bit write frame, then a 17-bit write frame -> no commit, err_cnt=2.
REQ-041 Write to addr 0x10 (NUM_REGS=5) -> no commit, err_cnt=0; a read of 0x10 -> CIPO all 0.
REQ-042 rst asserted after 9 bits of a write frame -> regs=RESET_VAL; the next complete frame commits correctly.
REQ-043 Rerun REQ-038 with NUM_REGS=16, ADDR_W=4, DATA_W=16: write 0xBEEF to addr 0xF -> regs_o[255:240]=0xBEEF.
